// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute/write-back sequencer with fetch timeout and halt detection
//   clk, rst (async, active-high) | run: start request (IDLE only)
//   imem_req/imem_addr/imem_ack/imem_rdata: instruction fetch handshake
//   pc, inst: current address and latched instruction
//   id_en/ex_en/wb_en: one-hot stage enables | commit/commit_cnt: retire pulse and count
//   state: FSM encoding | halted/fetch_err: sticky status
module cpu_seq_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int FETCH_TIMEOUT = 16,
  parameter logic [31:0] HALT_INST = 32'h0000_006b
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic imem_ack,
  input  logic [31:0] imem_rdata,
  output logic imem_req,
  output logic [63:0] imem_addr,
  output logic [63:0] pc,
  output logic [31:0] inst,
  output logic id_en,
  output logic ex_en,
  output logic wb_en,
  output logic commit,
  output logic [63:0] commit_cnt,
  output logic [2:0] state,
  output logic halted,
  output logic fetch_err
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
  state_t cur, nxt;
  logic [7:0] tcnt;
  logic timeout;
  assign timeout = tcnt == 8'(FETCH_TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cur <= IDLE;
    else cur <= nxt;
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    nxt = run ? FETCH : IDLE;
      FETCH:   nxt = imem_ack ? DECODE : timeout ? HALT : FETCH;
      DECODE:  nxt = EXEC;
      EXEC:    nxt = WB;
      WB:      nxt = inst == HALT_INST ? HALT : FETCH;
      default: nxt = cur;
    endcase
  end
  // The counter idles at zero outside FETCH, so every FETCH entry starts from 0.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      inst <= '0;
      commit_cnt <= '0;
      tcnt <= '0;
      halted <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      tcnt <= cur == FETCH ? tcnt + 8'd1 : 8'd0;
      if (cur == FETCH && imem_ack) inst <= imem_rdata;
      if (cur == FETCH && !imem_ack && timeout) fetch_err <= 1'b1;
      if (cur == WB) begin
        pc <= pc + 64'd4;
        commit_cnt <= commit_cnt + 64'd1;
        if (inst == HALT_INST) halted <= 1'b1;
      end
    end
  assign state = cur;
  assign imem_req = cur == FETCH;
  assign imem_addr = pc;
  assign id_en = cur == DECODE;
  assign ex_en = cur == EXEC;
  assign wb_en = cur == WB;
  assign commit = cur == WB;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed self-checking bench for cpu_seq_ctrl
module tb_cpu_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, id_en, ex_en, wb_en, commit, halted, fetch_err;
  logic [63:0] imem_addr, pc, commit_cnt;
  logic [31:0] inst;
  logic [2:0] state;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  cpu_seq_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .inst(inst),
    .id_en(id_en), .ex_en(ex_en), .wb_en(wb_en), .commit(commit),
    .commit_cnt(commit_cnt), .state(state), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_cmp++;
    if ($countones({id_en, ex_en, wb_en, imem_req}) > 1) begin
      n_err++;
      $display("FAIL onehot: got %b required at most one set", {id_en, ex_en, wb_en, imem_req});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    run = 1'b0;
    imem_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_pc", pc, 64'h8000_0000);
    chk("rst_addr", imem_addr, 64'h8000_0000);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_cnt", commit_cnt, 64'd0);
    chk("rst_flags", 64'({imem_req, id_en, ex_en, wb_en, commit, halted, fetch_err}), 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_hold", 64'(state), 64'd0);
    chk("idle_req", 64'(imem_req), 64'd0);
  endtask

  task automatic test_single;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("s_fetch", 64'(state), 64'd1);
    chk("s_req", 64'(imem_req), 64'd1);
    chk("s_addr", imem_addr, 64'h8000_0000);
    imem_ack = 1'b1;
    imem_rdata = 32'h0010_0093;
    tick();
    imem_ack = 1'b0;
    chk("s_id", 64'({id_en, ex_en, wb_en}), 64'b100);
    chk("s_inst", 64'(inst), 64'h0010_0093);
    tick();
    chk("s_ex", 64'({id_en, ex_en, wb_en}), 64'b010);
    tick();
    chk("s_wb", 64'({id_en, ex_en, wb_en, commit}), 64'b0011);
    tick();
    chk("s_back", 64'(state), 64'd1);
    chk("s_pc", pc, 64'h8000_0004);
    chk("s_cnt", commit_cnt, 64'd1);
    chk("s_commit_off", 64'(commit), 64'd0);
  endtask

  task automatic test_back_to_back;
    int last = 0;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (2) tick();
      chk("b_wait_fetch", 64'(state), 64'd1);
      imem_ack = 1'b1;
      imem_rdata = 32'h0000_0013;
      tick();
      imem_ack = 1'b0;
      repeat (2) tick();
      chk("b_commit", 64'(commit), 64'd1);
      if (k > 0) chk("b_spacing", 64'(cyc - last), 64'd6);
      last = cyc;
      tick();
    end
    chk("b_pc", pc, 64'h8000_000c);
    chk("b_cnt", commit_cnt, 64'd3);
    chk("b_state", 64'(state), 64'd1);
  endtask

  task automatic test_timeout;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (15) tick();
    chk("t_still_fetch", 64'(state), 64'd1);
    chk("t_no_err_yet", 64'(fetch_err), 64'd0);
    tick();
    chk("t_state", 64'(state), 64'd5);
    chk("t_err", 64'(fetch_err), 64'd1);
    chk("t_cnt", commit_cnt, 64'd0);
    imem_ack = 1'b1;
    repeat (2) tick();
    imem_ack = 1'b0;
    chk("t_req", 64'(imem_req), 64'd0);
    chk("t_stuck", 64'(state), 64'd5);
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (15) tick();
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    chk("t_last_ack", 64'(state), 64'd2);
    chk("t_last_err", 64'(fetch_err), 64'd0);
    chk("t_last_inst", 64'(inst), 64'h1234_5678);
  endtask

  task automatic test_halt;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_006b;
    tick();
    imem_ack = 1'b0;
    repeat (2) tick();
    chk("h_commit", 64'(commit), 64'd1);
    tick();
    chk("h_state", 64'(state), 64'd5);
    chk("h_halted", 64'(halted), 64'd1);
    chk("h_cnt", commit_cnt, 64'd1);
    run = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hffff_ffff;
    repeat (4) tick();
    run = 1'b0;
    imem_ack = 1'b0;
    chk("h_frozen_state", 64'(state), 64'd5);
    chk("h_frozen_pc", pc, 64'h8000_0004);
    chk("h_frozen_cnt", commit_cnt, 64'd1);
    chk("h_frozen_inst", 64'(inst), 64'h0000_006b);
    chk("h_quiet", 64'({imem_req, id_en, ex_en, wb_en, commit}), 64'd0);
  endtask

  task automatic test_reset_mid;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rf_req", 64'(imem_req), 64'd0);
    chk("rf_state", 64'(state), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    repeat (3) tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("re_in_exec", 64'(ex_en), 64'd1);
    chk("re_cnt_before", commit_cnt, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("re_state", 64'(state), 64'd0);
    chk("re_pc", pc, 64'h8000_0000);
    chk("re_cnt", commit_cnt, 64'd0);
    chk("re_en", 64'({imem_req, ex_en}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ack_ignored;
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 32'hdead_beef;
    tick();
    imem_ack = 1'b0;
    chk("a_idle_state", 64'(state), 64'd0);
    chk("a_idle_inst", 64'(inst), 64'd0);
    run = 1'b1;
    tick();
    run = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0010_0093;
    tick();
    imem_rdata = 32'hffff_ffff;
    tick();
    chk("a_dec_state", 64'(state), 64'd3);
    chk("a_dec_inst", 64'(inst), 64'h0010_0093);
    tick();
    imem_ack = 1'b0;
    chk("a_ex_state", 64'(state), 64'd4);
    chk("a_ex_inst", 64'(inst), 64'h0010_0093);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_ack_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
